// File: rtl/seq_divider_64_pkg.sv
// Shared definitions for the RV64M sequential divider: op encodings,
// FSM state codes and the signed-overflow dividend constant.
package seq_divider_64_pkg;

    // DIV/DIVU/REM/REMU encoding.
    // bit 1 selects the remainder; bit 0 marks the unsigned forms.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    // DIV and REM treat their operands as two's complement values.
    function automatic logic op_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/seq_divider_64_sub.sv
// 64-bit subtractor shared by the execute stage.
// borrow is set exactly when a < b, compared as unsigned numbers.
module seq_divider_64_sub (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] difference,
    output logic        borrow
);

    // The extra top bit of a 65-bit subtraction is the borrow out.
    assign {borrow, difference} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider_64.sv
// Multi-cycle restoring divider for RV64M DIV/DIVU/REM/REMU.
// One quotient bit is produced per cycle, MSB of the dividend first.
// Magnitudes are divided; signs are restored on the output path.
module seq_divider_64
    import seq_divider_64_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    div_state_e      state;
    div_op_e         op_q;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [5:0]      count;
    logic            q_neg;
    logic            r_neg;

    // Operand preparation in the accepting cycle.
    div_op_e         op_in;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            overflow;

    assign op_in       = div_op_e'(op);
    assign a_neg       = op_is_signed(op_in) & a[XLEN-1];
    assign b_neg       = op_is_signed(op_in) & b[XLEN-1];
    assign a_mag       = a_neg ? -a : a;
    assign b_mag       = b_neg ? -b : b;
    assign div_by_zero = (b == '0);
    assign overflow    = op_is_signed(op_in) && (a == INT_MIN) && (b == '1);

    // Trial subtraction: shift in the next dividend bit and compare against the divisor.
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] difference;
    logic            borrow;
    logic            take;

    assign rem_sh = {rem, dividend[XLEN-1]};
    assign take   = rem_sh[XLEN] | ~borrow;

    seq_divider_64_sub u_sub (
        .a          (rem_sh[XLEN-1:0]),
        .b          (divisor),
        .difference (difference),
        .borrow     (borrow)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Control FSM plus datapath registers; flush overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, datapath included, is reset so a mid-operation
        // reset leaves no stale quotient/remainder visible on the output path.
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_DIV;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments here; every register reads the
            // pre-edge values of the others, which the shift/subtract relies on.
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op_in;
                        if (div_by_zero) begin
                            // Quotient all-ones, remainder is the raw dividend.
                            quo   <= '1;
                            rem   <= a;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= S_DONE;
                        end else if (overflow) begin
                            quo   <= INT_MIN;
                            rem   <= '0;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            dividend <= a_mag;
                            divisor  <= b_mag;
                            quo      <= '0;
                            rem      <= '0;
                            count    <= '0;
                            q_neg    <= a_neg ^ b_neg;
                            r_neg    <= a_neg;
                            state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    dividend <= {dividend[XLEN-2:0], 1'b0};
                    quo      <= {quo[XLEN-2:0], take};
                    rem      <= take ? difference : rem_sh[XLEN-1:0];
                    count    <= count + 6'd1;
                    if (count == 6'(XLEN - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sign fix-up and quotient/remainder select; zero outside DONE.
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        result = '0;
        if (state == S_DONE) begin
            if (op_q[1]) begin
                result = r_neg ? -rem : rem;
            end else begin
                result = q_neg ? -quo : quo;
            end
        end
    end

endmodule
